// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types, default parameters and port-priority helper for
//          the multi-port register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } flush_state_t;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_NUM_WR   = 1;
    localparam int DEF_BYPASS   = 1;

    // Widest write-port match vector the priority helper accepts.
    localparam int MAX_WR = 16;

    // Index of the highest-numbered matching write port (0 when none match).
    function automatic int last_match(input logic [MAX_WR-1:0] match);
        int idx;
        idx = 0;
        for (int p = 0; p < MAX_WR; p++) begin
            if (match[p]) begin
                idx = p;
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module : regfile_scoreboard
// Brief  : Per-register busy bits for in-flight producers, with reserve,
//          write-clear, bulk flush clear and read-port lookup.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int BYPASS    = DEF_BYPASS,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 accept,
    input  logic                 flush_clr,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);

    logic r_busy [NUM_REGS];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_bit
        if (k == 0) begin : g_zero
            assign r_busy[k] = 1'b0;
        end else begin : g_reg
            logic w_clr;
            logic w_set;

            always_comb begin
                w_clr = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(k))) begin
                        w_clr = 1'b1;
                    end
                end
            end

            assign w_set = rsv_en && (rsv_addr == AW'(k));

            // A reservation beats a completing write: it names a newer producer.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_busy[k] <= 1'b0;
                end else if (flush_clr) begin
                    r_busy[k] <= 1'b0;
                end else if (accept) begin
                    if (w_set) begin
                        r_busy[k] <= 1'b1;
                    end else if (w_clr) begin
                        r_busy[k] <= 1'b0;
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_addr;

        assign w_addr = rd_addr[i*AW +: AW];

        if (BYPASS != 0) begin : g_byp
            logic w_wr_hit;
            logic w_rsv_hit;

            always_comb begin
                w_wr_hit = 1'b0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (wr_addr[p*AW +: AW] == w_addr)) begin
                        w_wr_hit = 1'b1;
                    end
                end
            end

            assign w_rsv_hit  = rsv_en && (rsv_addr == w_addr);
            assign rd_busy[i] = r_busy[w_addr] && !(accept && w_wr_hit && !w_rsv_hit);
        end else begin : g_nobyp
            assign rd_busy[i] = r_busy[w_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Parametrised multi-port register file with x0 hardwired to zero,
//          write-to-read bypass, busy scoreboard and a serial flush sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter int BYPASS   = DEF_BYPASS,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    input  logic                     clear_req,
    output logic                     clear_busy,
    output logic                     clear_done
);

    localparam logic [AW-1:0] C_LAST_IDX = AW'(NUM_REGS - 1);

    flush_state_t      r_state;
    flush_state_t      w_state_nxt;
    logic [AW-1:0]     r_idx;
    logic              r_done;
    logic              w_idle;
    logic              w_flush_start;
    logic              w_flush_last;
    logic [DATA_W-1:0] r_mem [NUM_REGS];
    logic [AW-1:0]     w_wr_addr [NUM_WR];
    logic [DATA_W-1:0] w_wr_data [NUM_WR];

    for (genvar p = 0; p < NUM_WR; p++) begin : g_wr
        assign w_wr_addr[p] = wr_addr[p*AW +: AW];
        assign w_wr_data[p] = wr_data[p*DATA_W +: DATA_W];
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_flush_start = 1'b0;
        w_flush_last  = 1'b0;
        w_idle        = 1'b0;
        clear_busy    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_idle = 1'b1;
                if (clear_req) begin
                    w_state_nxt   = ST_CLEAR;
                    w_flush_start = 1'b1;
                end
            end
            ST_CLEAR: begin
                clear_busy = 1'b1;
                if (r_idx == C_LAST_IDX) begin
                    w_state_nxt  = ST_IDLE;
                    w_flush_last = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Register 0 is never stored, so the walk starts at 1 and ends on the
    // last register; the wrap back to 0 afterwards is never used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_flush_last;
            if (w_flush_start) begin
                r_idx <= AW'(1);
            end else if (r_state == ST_CLEAR) begin
                r_idx <= r_idx + AW'(1);
            end
        end
    end

    assign clear_done = r_done;

    // -------------------------------------------------------------- array
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == 0) begin : g_zero
            assign r_mem[k] = '0;
        end else begin : g_store
            logic              w_hit;
            logic [DATA_W-1:0] w_wdata;

            // Later ports overwrite earlier ones: highest index wins.
            always_comb begin
                w_hit   = 1'b0;
                w_wdata = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    if (wr_en[p] && (w_wr_addr[p] == AW'(k))) begin
                        w_hit   = 1'b1;
                        w_wdata = w_wr_data[p];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[k] <= '0;
                end else if (r_state == ST_CLEAR) begin
                    if (r_idx == AW'(k)) begin
                        r_mem[k] <= '0;
                    end
                end else if (w_hit) begin
                    r_mem[k] <= w_wdata;
                end
            end
        end
    end

    // --------------------------------------------------------- read ports
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]     w_addr;
        logic [DATA_W-1:0] w_val;

        assign w_addr = rd_addr[i*AW +: AW];

        if (BYPASS != 0) begin : g_byp
            logic [MAX_WR-1:0] w_match;
            int                w_sel;

            // Writes are ignored while flushing, so nothing is forwarded then.
            always_comb begin
                w_match = '0;
                for (int p = 0; p < NUM_WR; p++) begin
                    w_match[p] = w_idle && wr_en[p] && (w_wr_addr[p] == w_addr)
                                 && (w_addr != '0);
                end
            end

            assign w_sel = last_match(w_match);
            assign w_val = (|w_match) ? w_wr_data[w_sel] : r_mem[w_addr];
        end else begin : g_nobyp
            assign w_val = r_mem[w_addr];
        end

        assign rd_data[i*DATA_W +: DATA_W] = w_val;
    end

    // ---------------------------------------------------------- scoreboard
    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (w_idle),
        .flush_clr (w_flush_start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Self-checking bench for regfile_mp (bypass and non-bypass builds).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int DW  = 64;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW  = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data, rd_data_nb;
    logic [NRD-1:0]    rd_busy, rd_busy_nb;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic              rsv_en;
    logic [AW-1:0]     rsv_addr;
    logic              clear_req;
    logic              clear_busy, clear_done, clear_busy_nb, clear_done_nb;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .clear_req(clear_req), .clear_busy(clear_busy),
        .clear_done(clear_done));

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .clear_req(clear_req), .clear_busy(clear_busy_nb),
        .clear_done(clear_done_nb));

    // ------------------------------------------------ reference model state
    logic [DW-1:0] m_mem [NR];
    bit            m_busy [NR];
    int            m_flush_left;   // registers still to be zeroed; 0 = idle
    bit            m_done;

    int checks = 0;
    int errors = 0;
    int cb_cnt = 0;
    int cd_cnt = 0;

    task automatic model_reset();
        for (int k = 0; k < NR; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_flush_left = 0;
        m_done       = 1'b0;
    endtask

    task automatic model_step();
        int a;
        m_done = 1'b0;
        if (m_flush_left == 0) begin
            for (int p = 0; p < NWR; p++) begin
                a = int'(wr_addr[p*AW +: AW]);
                if (wr_en[p] && a != 0) begin
                    m_mem[a]  = wr_data[p*DW +: DW];
                    m_busy[a] = 1'b0;
                end
            end
            if (rsv_en && rsv_addr != 0) m_busy[int'(rsv_addr)] = 1'b1;
            if (clear_req) begin
                m_flush_left = NR - 1;
                for (int k = 0; k < NR; k++) m_busy[k] = 1'b0;
            end
        end else begin
            m_mem[NR - m_flush_left] = '0;
            m_flush_left--;
            if (m_flush_left == 0) m_done = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int a, input bit byp);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = m_mem[a];
        if (byp && m_flush_left == 0) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) v = wr_data[p*DW +: DW];
            end
        end
        return v;
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        bit hit;
        if (a == 0) return 1'b0;
        if (!byp || m_flush_left != 0) return m_busy[a];
        hit = 1'b0;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) hit = 1'b1;
        end
        return m_busy[a] && !(hit && !(rsv_en && int'(rsv_addr) == a));
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            chk($sformatf("%s rd_data[%0d] x%0d", tag, i, a), rd_data[i*DW +: DW], exp_data(a, 1'b1));
            chk($sformatf("%s nb rd_data[%0d] x%0d", tag, i, a), rd_data_nb[i*DW +: DW], exp_data(a, 1'b0));
            chk($sformatf("%s rd_busy[%0d] x%0d", tag, i, a), DW'(rd_busy[i]), DW'(exp_busy(a, 1'b1)));
            chk($sformatf("%s nb rd_busy[%0d] x%0d", tag, i, a), DW'(rd_busy_nb[i]), DW'(exp_busy(a, 1'b0)));
        end
        chk($sformatf("%s clear_busy", tag), DW'(clear_busy), DW'(m_flush_left != 0));
        chk($sformatf("%s clear_done", tag), DW'(clear_done), DW'(m_done));
        chk($sformatf("%s nb clear_busy", tag), DW'(clear_busy_nb), DW'(m_flush_left != 0));
        chk($sformatf("%s nb clear_done", tag), DW'(clear_done_nb), DW'(m_done));
    endtask

    task automatic cycle(input bit do_chk, input string tag);
        @(negedge clk);
        cb_cnt += int'(clear_busy);
        cd_cnt += int'(clear_done);
        if (do_chk) check_model(tag);
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; clear_req = 1'b0;
    endtask

    task automatic junk_inputs(input bit allow_clear);
        wr_en     = NWR'($urandom());
        wr_addr   = NWR*AW'($urandom());
        wr_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
        rsv_en    = 1'($urandom());
        rsv_addr  = AW'($urandom());
        clear_req = allow_clear ? ($urandom_range(0, 49) == 0) : 1'b0;
        rd_addr   = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
    endtask

    task automatic fill();
        for (int k = 1; k < NR; k += 2) begin
            wr_en   = (k + 1 < NR) ? 2'b11 : 2'b01;
            wr_addr = {AW'(k + 1), AW'(k)};
            wr_data = {$urandom(), $urandom() | 32'h1, $urandom(), $urandom() | 32'h1};
            rsv_en  = 1'b0;
            rd_addr = {AW'(k + 1), AW'(k)};
            cycle(1'b1, "fill");
        end
        idle_inputs();
    endtask

    // ------------------------------------------------------ directed table
    typedef struct {
        logic [1:0]    wen;
        logic [AW-1:0] wa0;
        logic [DW-1:0] wd0;
        logic [AW-1:0] wa1;
        logic [DW-1:0] wd1;
        logic          rsv;
        logic [AW-1:0] ra;
        logic [AW-1:0] rd0;
        logic [AW-1:0] rd1;
        logic [DW-1:0] e_d0;
        logic [DW-1:0] e_d1;
        logic [DW-1:0] e_nb0;
        logic          e_b0;
        logic          e_b1;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] wen, input int wa0, input logic [DW-1:0] wd0,
                                input int wa1, input logic [DW-1:0] wd1, input bit rsv, input int ra,
                                input int rd0, input int rd1, input logic [DW-1:0] e_d0,
                                input logic [DW-1:0] e_d1, input logic [DW-1:0] e_nb0,
                                input bit e_b0, input bit e_b1);
        vec_t v;
        v.wen = wen; v.wa0 = AW'(wa0); v.wd0 = wd0; v.wa1 = AW'(wa1); v.wd1 = wd1;
        v.rsv = rsv; v.ra = AW'(ra); v.rd0 = AW'(rd0); v.rd1 = AW'(rd1);
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_nb0 = e_nb0; v.e_b0 = e_b0; v.e_b1 = e_b1;
        return v;
    endfunction

    localparam int NVEC = 14;
    vec_t tbl [NVEC];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rd_addr = '0;
        model_reset();

        // Reset state, swept across every address while reset is held.
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < NR; a++) begin
            rd_addr = {AW'(a), AW'(NR - 1 - a)};
            #1;
            check_model("reset");
        end
        rst_n = 1'b1;

        tbl[0]  = mk(2'b01, 5, 64'hDEAD_BEEF, 0, 0,     0, 0, 5, 0, 64'hDEAD_BEEF, 0,             0,             0, 0);
        tbl[1]  = mk(2'b00, 0, 0,             0, 0,     0, 0, 5, 5, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 0);
        tbl[2]  = mk(2'b01, 0, 8,             0, 0,     1, 0, 0, 5, 0,             64'hDEAD_BEEF, 0,             0, 0);
        tbl[3]  = mk(2'b00, 0, 0,             0, 0,     0, 0, 0, 5, 0,             64'hDEAD_BEEF, 0,             0, 0);
        tbl[4]  = mk(2'b11, 7, 64'h11,        7, 64'h22, 0, 0, 7, 0, 64'h22,       0,             0,             0, 0);
        tbl[5]  = mk(2'b00, 0, 0,             0, 0,     0, 0, 7, 5, 64'h22,        64'hDEAD_BEEF, 64'h22,        0, 0);
        tbl[6]  = mk(2'b00, 0, 0,             0, 0,     1, 3, 3, 7, 0,             64'h22,        0,             0, 0);
        tbl[7]  = mk(2'b00, 0, 0,             0, 0,     0, 0, 3, 7, 0,             64'h22,        0,             1, 0);
        tbl[8]  = mk(2'b01, 3, 64'h33,        0, 0,     0, 0, 3, 0, 64'h33,        0,             0,             0, 0);
        tbl[9]  = mk(2'b00, 0, 0,             0, 0,     0, 0, 3, 0, 64'h33,        0,             64'h33,        0, 0);
        tbl[10] = mk(2'b10, 0, 0,             3, 64'h44, 1, 3, 3, 0, 64'h44,       0,             64'h33,        0, 0);
        tbl[11] = mk(2'b00, 0, 0,             0, 0,     0, 0, 3, 0, 64'h44,        0,             64'h44,        1, 0);
        tbl[12] = mk(2'b11, 3, 64'h55,        3, 64'h66, 1, 9, 3, 9, 64'h66,       0,             64'h44,        0, 0);
        tbl[13] = mk(2'b00, 0, 0,             0, 0,     0, 0, 3, 9, 64'h66,        0,             64'h66,        0, 1);

        for (int r = 0; r < NVEC; r++) begin
            wr_en     = tbl[r].wen;
            wr_addr   = {tbl[r].wa1, tbl[r].wa0};
            wr_data   = {tbl[r].wd1, tbl[r].wd0};
            rsv_en    = tbl[r].rsv;
            rsv_addr  = tbl[r].ra;
            clear_req = 1'b0;
            rd_addr   = {tbl[r].rd1, tbl[r].rd0};
            @(negedge clk);
            chk($sformatf("vec%0d rd_data0", r), rd_data[DW-1:0], tbl[r].e_d0);
            chk($sformatf("vec%0d rd_data1", r), rd_data[2*DW-1:DW], tbl[r].e_d1);
            chk($sformatf("vec%0d nb rd_data0", r), rd_data_nb[DW-1:0], tbl[r].e_nb0);
            chk($sformatf("vec%0d rd_busy0", r), DW'(rd_busy[0]), DW'(tbl[r].e_b0));
            chk($sformatf("vec%0d rd_busy1", r), DW'(rd_busy[1]), DW'(tbl[r].e_b1));
            @(posedge clk);
            model_step();
            #1;
        end
        idle_inputs();

        // Full flush: write lands at the start edge, then everything is zeroed.
        fill();
        clear_req = 1'b1;
        wr_en = 2'b01; wr_addr = {AW'(0), AW'(4)}; wr_data = {64'h0, 64'hABCD};
        rd_addr = {AW'(4), AW'(4)};
        cycle(1'b1, "flush_start");
        cb_cnt = 0;
        cd_cnt = 0;
        for (int c = 0; c < NR - 1; c++) begin
            junk_inputs(1'b1);
            cycle(1'b1, "flushing");
        end
        idle_inputs();
        repeat (3) cycle(1'b1, "flush_end");
        chk("flush_busy_cycles", DW'(cb_cnt), DW'(NR - 1));
        chk("flush_done_pulses", DW'(cd_cnt), DW'(1));
        for (int a = 0; a < NR; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            cycle(1'b1, "after_flush");
        end

        // Reset in the middle of a flush aborts it without a done pulse.
        fill();
        clear_req = 1'b1;
        cycle(1'b1, "flush2_start");
        idle_inputs();
        for (int c = 0; c < 10; c++) begin
            rd_addr = {AW'(31), AW'(20)};
            cycle(1'b1, "flush2");
        end
        rst_n = 1'b0;
        #2;
        model_reset();
        check_model("abort_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cd_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            rd_addr = {AW'(c % NR), AW'((c + 16) % NR)};
            cycle(1'b1, "post_abort");
        end
        chk("abort_no_done", DW'(cd_cnt), DW'(0));

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            junk_inputs(1'b1);
            rsv_en = ($urandom_range(0, 9) < 3);
            wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            rsv_addr = AW'($urandom_range(0, 7));
            cycle(1'b1, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
